register_bank: RTL

//  Parametrised multi-entry successor to the single datapath register: NUM_REGS words of DATA_WIDTH,
//  one synchronous write port, one synchronous single-entry clear, two asynchronous read ports.

---
 rtl/register_bank_pkg.sv | 12 +
 rtl/register_bank_entry.sv | 23 ++
 rtl/register_bank.sv | 79 +++++++
 3 files changed

// File: rtl/register_bank_pkg.sv
// Shared constants, types and helpers for the register bank.
package register_bank_pkg;
  localparam int DEF_DATA_WIDTH = 11;
  localparam int WR_CNT_W       = 8;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

  // Index width for n entries; never below one bit.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/register_bank_entry.sv
// One storage word: sync reset, then clear, then write enable, in that priority.
module register_bank_entry
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  bank_reset,
  input  logic                  i_clr,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clock) begin
    if (bank_reset)  r_q <= '0;
    else if (i_clr)  r_q <= '0;
    else if (i_wr)   r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/register_bank.sv
// General-purpose register set: one write port, one single-entry clear, two async read ports.
// Optional write-through forwarding when REGISTER_BANK_BYPASS_EN is defined.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int   DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int   NUM_REGS   = 8,
  parameter bit   ZERO_REG   = 1'b0,
  localparam int  ADDR_WIDTH = addr_width(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  bank_reset,
  input  logic                  bank_wr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] bank_in,
  input  logic                  bank_clr,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] bank_out_a,
  output logic [DATA_WIDTH-1:0] bank_out_b,
  output logic [WR_CNT_W-1:0]   wr_count
);
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_q;
  logic [DATA_WIDTH-1:0]               w_rd_a, w_rd_b;
  logic                                w_wr_ok, w_wr_acc;
  logic [WR_CNT_W-1:0]                 r_wr_count;

  // A write targets real storage: in range and not the hardwired zero entry.
  assign w_wr_ok  = bank_wr && (int'(wr_addr) < NUM_REGS) && !(ZERO_REG && wr_addr == '0);
  assign w_wr_acc = w_wr_ok && !(bank_clr && clr_addr == wr_addr);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ent
    if (ZERO_REG && g == 0) begin : g_zero
      assign w_q[g] = '0;
    end else begin : g_reg
      logic w_wr_hit, w_clr_hit;
      assign w_wr_hit  = bank_wr  && (wr_addr  == ADDR_WIDTH'(g));
      assign w_clr_hit = bank_clr && (clr_addr == ADDR_WIDTH'(g));
      register_bank_entry #(.DATA_WIDTH(DATA_WIDTH)) u_ent (
        .clock      (clock),
        .bank_reset (bank_reset),
        .i_clr      (w_clr_hit),
        .i_wr       (w_wr_hit),
        .i_d        (bank_in),
        .o_q        (w_q[g])
      );
    end
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_a == ADDR_WIDTH'(i)) w_rd_a = w_q[i];
      if (rd_addr_b == ADDR_WIDTH'(i)) w_rd_b = w_q[i];
    end
  end

`ifdef REGISTER_BANK_BYPASS_EN
  logic                  w_fwd;
  logic [DATA_WIDTH-1:0] w_fwd_d;
  assign w_fwd      = w_wr_ok && !bank_reset;
  assign w_fwd_d    = (bank_clr && clr_addr == wr_addr) ? '0 : bank_in;
  assign bank_out_a = (w_fwd && rd_addr_a == wr_addr) ? w_fwd_d : w_rd_a;
  assign bank_out_b = (w_fwd && rd_addr_b == wr_addr) ? w_fwd_d : w_rd_b;
`else
  assign bank_out_a = w_rd_a;
  assign bank_out_b = w_rd_b;
`endif

  always_ff @(posedge clock) begin
    if (bank_reset)                        r_wr_count <= '0;
    else if (w_wr_acc && r_wr_count != '1) r_wr_count <= r_wr_count + 1'b1;
  end

  assign wr_count = r_wr_count;
endmodule
